// File: rtl/s2_event_monitor_pkg.sv
// -----------------------------------------------------------------------------
// s2_pkg
// Definitions shared by the S2 event monitor and its neighbours.
//   - S2_ST0..S2_ST3 : state codes emitted by the S2 run detector on state2.
//                      S2_ST3 (2'b11) marks a full run.
//   - burst_state_t  : encoding of the burst-alarm FSM (IDLE/WATCH/ALARM).
// -----------------------------------------------------------------------------
package s2_pkg;

    localparam logic [1:0] S2_ST0 = 2'b00;
    localparam logic [1:0] S2_ST1 = 2'b01;
    localparam logic [1:0] S2_ST2 = 2'b10;
    localparam logic [1:0] S2_ST3 = 2'b11;

    typedef enum logic [1:0] {
        BURST_IDLE  = 2'd0,
        BURST_WATCH = 2'd1,
        BURST_ALARM = 2'd2
    } burst_state_t;

endpackage

// File: rtl/s2_event_monitor_if.sv
// -----------------------------------------------------------------------------
// s2_event_monitor_if
// Bundles the monitor's data-path signals.
//   master (driver side) : drives y2_in, state2_in, clr, rd_en
//   slave  (monitor)     : drives rd_data, empty, full, overflow,
//                          evt_count, run_count, alarm, dbg_state
// Pop handshake: rd_data is valid whenever empty is low (first-word
// fall-through). Asserting rd_en while empty is low consumes the head entry
// at that posedge; rd_en while empty is high is ignored.
// -----------------------------------------------------------------------------
interface s2_event_monitor_if #(
    parameter int CNT_W = 8
);
    import s2_pkg::*;

    logic             y2_in;
    logic [1:0]       state2_in;
    logic             clr;
    logic             rd_en;
    logic [1:0]       rd_data;
    logic             empty;
    logic             full;
    logic             overflow;
    logic [CNT_W-1:0] evt_count;
    logic [CNT_W-1:0] run_count;
    logic             alarm;
    burst_state_t     dbg_state;

    modport master (
        output y2_in, state2_in, clr, rd_en,
        input  rd_data, empty, full, overflow, evt_count, run_count, alarm,
               dbg_state
    );

    modport slave (
        input  y2_in, state2_in, clr, rd_en,
        output rd_data, empty, full, overflow, evt_count, run_count, alarm,
               dbg_state
    );

endinterface

// File: rtl/s2_event_monitor_fifo.sv
// -----------------------------------------------------------------------------
// s2_evt_fifo
// DEPTH x 2-bit first-word-fall-through FIFO.
//   clk     : clock
//   i_clr   : synchronous clear (empties the FIFO)
//   i_push  : write i_data; accepted when not full, or when full and a pop
//             is accepted in the same cycle
//   i_pop   : remove head; ignored when empty
//   i_data  : code to write
//   o_data  : head entry, 2'b00 when empty
//   o_empty : no entries
//   o_full  : DEPTH entries
// -----------------------------------------------------------------------------
module s2_evt_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       i_clr,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [1:0] i_data,
    output logic [1:0] o_data,
    output logic       o_empty,
    output logic       o_full
);

    // One extra pointer bit distinguishes full from empty.
    localparam int PW = $clog2(DEPTH) + 1;

    logic [1:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          w_do_pop;
    logic          w_do_push;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                       (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? 2'b00 : r_mem[r_rptr[PW-2:0]];

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
        end
    end

    // Storage needs no clear: o_data is masked while empty.
    always_ff @(posedge clk) begin
        if (!i_clr && w_do_push) r_mem[r_wptr[PW-2:0]] <= i_data;
    end

endmodule

// File: rtl/s2_event_monitor.sv
// -----------------------------------------------------------------------------
// s2_event_monitor
// Turns each rising edge of S2's Y2 into an event, logs the S2 state code of
// the event in a FWFT FIFO, counts events (saturating) and raises a sticky
// alarm when BURST_N events fall inside a WINDOW-cycle observation window.
//   clk   : clock, all state updates on posedge
//   reset : synchronous active-high reset
//   mon   : s2_event_monitor_if slave modport (inputs y2_in, state2_in, clr,
//           rd_en; outputs rd_data, empty, full, overflow, evt_count,
//           run_count, alarm, dbg_state)
// -----------------------------------------------------------------------------
module s2_event_monitor
    import s2_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter int BURST_N = 3,
    parameter int WINDOW  = 16
) (
    input  logic                clk,
    input  logic                reset,
    s2_event_monitor_if.slave   mon
);

    localparam int TMR_W = $clog2(WINDOW);
    localparam int BST_W = $clog2(BURST_N + 1);

    logic             w_clear;
    logic             r_y_q;
    logic             w_event;
    logic [1:0]       w_rd_data;
    logic             w_empty;
    logic             w_full;
    logic             r_overflow;
    logic [CNT_W-1:0] r_evt_count;
    logic [CNT_W-1:0] r_run_count;
    logic             r_alarm;

    burst_state_t     r_state;
    burst_state_t     w_next_state;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_next_timer;
    logic [BST_W-1:0] r_burst;
    logic [BST_W-1:0] w_next_burst;
    logic [BST_W-1:0] w_burst_upd;

    // clr has exactly the effect of reset, so both collapse onto one clear.
    assign w_clear = reset || mon.clr;
    assign w_event = mon.y2_in && !r_y_q;

    s2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .i_clr   (w_clear),
        .i_push  (w_event),
        .i_pop   (mon.rd_en),
        .i_data  (mon.state2_in),
        .o_data  (w_rd_data),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_y_q       <= 1'b0;
            r_overflow  <= 1'b0;
            r_evt_count <= '0;
            r_run_count <= '0;
        end else begin
            r_y_q <= mon.y2_in;
            // Dropped only when full and the head is not leaving this cycle.
            if (w_event && w_full && !mon.rd_en) r_overflow <= 1'b1;
            if (w_event && (r_evt_count != '1))
                r_evt_count <= r_evt_count + CNT_W'(1);
            if (w_event && (mon.state2_in == S2_ST3) && (r_run_count != '1))
                r_run_count <= r_run_count + CNT_W'(1);
        end
    end

    // Burst FSM state register.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= BURST_IDLE;
            r_timer <= '0;
            r_burst <= '0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_timer <= w_next_timer;
            r_burst <= w_next_burst;
            r_alarm <= (w_next_state == BURST_ALARM);
        end
    end

    // Burst FSM next state. In WATCH the event of the current cycle is added
    // before the timeout test, so an event on the last window cycle counts.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        w_next_burst = r_burst;
        w_burst_upd  = r_burst + BST_W'(w_event);
        case (r_state)
            BURST_IDLE: begin
                if (w_event) begin
                    w_next_state = BURST_WATCH;
                    w_next_timer = '0;
                    w_next_burst = BST_W'(1);
                end
            end
            BURST_WATCH: begin
                w_next_timer = r_timer + TMR_W'(1);
                w_next_burst = w_burst_upd;
                if (w_burst_upd == BST_W'(BURST_N))
                    w_next_state = BURST_ALARM;
                else if (r_timer == TMR_W'(WINDOW - 1))
                    w_next_state = BURST_IDLE;
            end
            BURST_ALARM: begin
                w_next_state = BURST_ALARM;
            end
            default: begin
                w_next_state = BURST_IDLE;
            end
        endcase
    end

    assign mon.rd_data   = w_rd_data;
    assign mon.empty     = w_empty;
    assign mon.full      = w_full;
    assign mon.overflow  = r_overflow;
    assign mon.evt_count = r_evt_count;
    assign mon.run_count = r_run_count;
    assign mon.alarm     = r_alarm;
    assign mon.dbg_state = r_state;

endmodule

// File: tb/tb_s2_event_monitor.sv
// -----------------------------------------------------------------------------
// tb_s2_event_monitor
// Directed steps followed by a random phase. Two monitors share one stimulus:
// the main one (CNT_W=8) and a narrow one (CNT_W=3) for counter saturation.
// Expected values come from a queue/arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_s2_event_monitor;
    import s2_pkg::*;

    localparam int DEPTH   = 4;
    localparam int BURST_N = 3;
    localparam int WINDOW  = 16;

    logic clk;
    logic reset;

    s2_event_monitor_if #(.CNT_W(8)) mif ();
    s2_event_monitor_if #(.CNT_W(3)) sif ();

    assign sif.y2_in     = mif.y2_in;
    assign sif.state2_in = mif.state2_in;
    assign sif.clr       = mif.clr;
    assign sif.rd_en     = mif.rd_en;

    s2_event_monitor #(.DEPTH(DEPTH), .CNT_W(8), .BURST_N(BURST_N),
                       .WINDOW(WINDOW)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mif.slave)
    );

    s2_event_monitor #(.DEPTH(DEPTH), .CNT_W(3), .BURST_N(BURST_N),
                       .WINDOW(WINDOW)) dut_narrow (
        .clk   (clk),
        .reset (reset),
        .mon   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [1:0] exp_q[$];
    logic       m_prev_y;
    logic       m_ovf;
    int         m_evt;
    int         m_run;
    logic       m_alarm;
    logic       win_valid;
    int         win_s;
    int         win_cnt;
    int         cyc;
    burst_state_t m_state;

    function automatic int sat(int v, int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(logic y, logic [1:0] s, logic c, logic rd,
                                logic rs);
        logic evt;
        int   t;
        t = cyc;
        cyc++;
        if (rs || c) begin
            exp_q.delete();
            m_ovf     = 1'b0;
            m_evt     = 0;
            m_run     = 0;
            m_alarm   = 1'b0;
            win_valid = 1'b0;
            m_prev_y  = 1'b0;
        end else begin
            evt = y && !m_prev_y;
            if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
            if (evt) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(s);
                else m_ovf = 1'b1;
                m_evt++;
                if (s == 2'b11) m_run++;
                if (!m_alarm) begin
                    // Window covers the WINDOW cycles following its first event.
                    if (!win_valid || (t - win_s) > WINDOW) begin
                        win_valid = 1'b1;
                        win_s     = t;
                        win_cnt   = 1;
                    end else begin
                        win_cnt++;
                        if (win_cnt >= BURST_N) m_alarm = 1'b1;
                    end
                end
            end
            m_prev_y = y;
        end
        if (m_alarm) m_state = BURST_ALARM;
        else if (win_valid && (t + 1 - win_s) <= WINDOW) m_state = BURST_WATCH;
        else m_state = BURST_IDLE;
    endtask

    task automatic check_all();
        logic [1:0] exp_rd;
        exp_rd = (exp_q.size() > 0) ? exp_q[0] : 2'b00;
        chk("rd_data",   32'(mif.rd_data),   32'(exp_rd));
        chk("empty",     32'(mif.empty),     32'(exp_q.size() == 0));
        chk("full",      32'(mif.full),      32'(exp_q.size() == DEPTH));
        chk("overflow",  32'(mif.overflow),  32'(m_ovf));
        chk("evt_count", 32'(mif.evt_count), 32'(sat(m_evt, 8)));
        chk("run_count", 32'(mif.run_count), 32'(sat(m_run, 8)));
        chk("alarm",     32'(mif.alarm),     32'(m_alarm));
        chk("state",     32'(mif.dbg_state), 32'(m_state));
        chk("evt_count_w3", 32'(sif.evt_count), 32'(sat(m_evt, 3)));
        chk("run_count_w3", 32'(sif.run_count), 32'(sat(m_run, 3)));
    endtask

    // One clock: capture the inputs the DUT samples, advance, then check.
    task automatic tick();
        logic       y, c, rd, rs;
        logic [1:0] s;
        y  = mif.y2_in;
        s  = mif.state2_in;
        c  = mif.clr;
        rd = mif.rd_en;
        rs = reset;
        @(posedge clk);
        #1;
        model_update(y, s, c, rd, rs);
        check_all();
    endtask

    task automatic pulse(logic [1:0] code);
        mif.y2_in     = 1'b1;
        mif.state2_in = code;
        tick();
        mif.y2_in     = 1'b0;
        tick();
    endtask

    task automatic clear_pulse();
        mif.clr = 1'b1;
        tick();
        mif.clr = 1'b0;
    endtask

    logic [1:0] codes_a [4];
    logic [1:0] codes_b [4];

    initial begin
        m_prev_y = 1'b0; m_ovf = 1'b0; m_evt = 0; m_run = 0; m_alarm = 1'b0;
        win_valid = 1'b0; win_s = 0; win_cnt = 0; cyc = 0; m_state = BURST_IDLE;
        codes_a = '{2'b00, 2'b01, 2'b10, 2'b11};
        codes_b = '{2'b10, 2'b01, 2'b00, 2'b11};

        reset         = 1'b1;
        mif.y2_in     = 1'b1;
        mif.state2_in = 2'b11;
        mif.clr       = 1'b0;
        mif.rd_en     = 1'b0;

        // Reset held two cycles with y2_in high.
        tick();
        tick();
        chk("rst_evt",   32'(mif.evt_count), 32'd0);
        chk("rst_empty", 32'(mif.empty),     32'd1);
        chk("rst_alarm", 32'(mif.alarm),     32'd0);
        chk("rst_rd",    32'(mif.rd_data),   32'd0);

        // Release with y2_in still high: one event, then level held.
        reset = 1'b0;
        tick();
        chk("lvl_evt", 32'(mif.evt_count), 32'd1);
        chk("lvl_run", 32'(mif.run_count), 32'd1);
        chk("lvl_rd",  32'(mif.rd_data),   32'd3);
        for (int i = 0; i < 4; i++) tick();
        chk("lvl_hold", 32'(mif.evt_count), 32'd1);
        mif.y2_in = 1'b0;
        tick();
        pulse(2'b01);
        chk("pulse_evt", 32'(mif.evt_count), 32'd2);
        chk("pulse_run", 32'(mif.run_count), 32'd1);

        // Fill past DEPTH without reads.
        clear_pulse();
        pulse(2'b00); pulse(2'b01); pulse(2'b10);
        pulse(2'b11); pulse(2'b01); pulse(2'b10);
        chk("fill_full", 32'(mif.full),      32'd1);
        chk("fill_ovf",  32'(mif.overflow),  32'd1);
        chk("fill_evt",  32'(mif.evt_count), 32'd6);
        mif.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pop_order", 32'(mif.rd_data), 32'(codes_a[i]));
            tick();
        end
        mif.rd_en = 1'b0;
        chk("drain_empty", 32'(mif.empty),   32'd1);
        chk("drain_rd",    32'(mif.rd_data), 32'd0);

        // Push and pop together while full.
        clear_pulse();
        pulse(2'b11); pulse(2'b10); pulse(2'b01); pulse(2'b00);
        mif.y2_in     = 1'b1;
        mif.state2_in = 2'b11;
        mif.rd_en     = 1'b1;
        tick();
        mif.y2_in = 1'b0;
        mif.rd_en = 1'b0;
        chk("pp_full", 32'(mif.full),     32'd1);
        chk("pp_ovf",  32'(mif.overflow), 32'd0);
        tick();
        mif.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_order", 32'(mif.rd_data), 32'(codes_b[i]));
            tick();
        end
        mif.rd_en = 1'b0;

        // Three events four cycles apart raise the alarm.
        clear_pulse();
        for (int k = 0; k < 3; k++) begin
            chk("burst_pre", 32'(mif.alarm), 32'd0);
            mif.y2_in = 1'b1;
            tick();
            mif.y2_in = 1'b0;
            if (k < 2) begin
                for (int i = 0; i < 3; i++) tick();
            end
        end
        chk("burst_alarm", 32'(mif.alarm),     32'd1);
        chk("burst_state", 32'(mif.dbg_state), 32'(BURST_ALARM));

        // Two events, long gap, one event: window expired, new watch.
        clear_pulse();
        pulse(2'b01);
        tick(); tick();
        pulse(2'b01);
        for (int i = 0; i < 20; i++) tick();
        chk("gap_idle", 32'(mif.dbg_state), 32'(BURST_IDLE));
        pulse(2'b01);
        chk("gap_alarm", 32'(mif.alarm),     32'd0);
        chk("gap_state", 32'(mif.dbg_state), 32'(BURST_WATCH));

        // Saturation on the narrow counters, then clear.
        clear_pulse();
        for (int i = 0; i < 10; i++) pulse(2'b11);
        chk("sat_evt_w3", 32'(sif.evt_count), 32'd7);
        chk("sat_run_w3", 32'(sif.run_count), 32'd7);
        chk("sat_evt_w8", 32'(mif.evt_count), 32'd10);
        clear_pulse();
        chk("clr_evt",   32'(mif.evt_count), 32'd0);
        chk("clr_run",   32'(mif.run_count), 32'd0);
        chk("clr_alarm", 32'(mif.alarm),     32'd0);
        chk("clr_empty", 32'(mif.empty),     32'd1);
        chk("clr_ovf",   32'(mif.overflow),  32'd0);

        // Random phase against the reference model.
        for (int i = 0; i < 300; i++) begin
            mif.y2_in     = 1'($urandom_range(0, 1));
            mif.state2_in = 2'($urandom_range(0, 3));
            mif.rd_en     = ($urandom_range(0, 3) == 0);
            mif.clr       = ($urandom_range(0, 39) == 0);
            reset         = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset     = 1'b0;
        mif.clr   = 1'b0;
        mif.rd_en = 1'b0;
        mif.y2_in = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
